seg_capture: RTL and testbench

Receiver for the stopwatch's multiplexed, active-low seven-segment bus. Watches the anode and segment lines driven by the display block, waits for each digit to settle, decodes the segment pattern back to a digit code and assembles the four digits into a frame. It sits beside the display output as a self-check and readback path, so benches and on-chip logic can recover the displayed time without a scope.

---
 rtl/seg_capture.sv | 157 +++++++++++++++
 tb/tb_seg_capture.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_capture.sv
// Readback receiver for the multiplexed active-low seven-segment bus: waits for each digit to settle,
// decodes it into its slot and publishes a frame once all four digits are seen. Optional: SEG_CAPTURE_DP_EN.
module seg_capture #(
   parameter int unsigned SETTLE = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] an,
   input  logic [6:0] seg,
   input  logic       dp,
   output logic [3:0] min_l,
   output logic [3:0] min_r,
   output logic [3:0] sec_l,
   output logic [3:0] sec_r,
   output logic [3:0] err,
   output logic [3:0] dp_out,
   output logic       frame_valid
);

   localparam int unsigned CW = $clog2(SETTLE + 1);
   localparam int unsigned IW = 12;
   localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

   // Returns {err, code}
   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'h40:   decode = 5'h00;
         7'h79:   decode = 5'h01;
         7'h24:   decode = 5'h02;
         7'h30:   decode = 5'h03;
         7'h19:   decode = 5'h04;
         7'h12:   decode = 5'h05;
         7'h02:   decode = 5'h06;
         7'h78:   decode = 5'h07;
         7'h00:   decode = 5'h08;
         7'h10:   decode = 5'h09;
         7'h7F:   decode = 5'h0B;
         default: decode = 5'h1F;
      endcase
   endfunction

   // With the feature off, dp is forced high so it never disturbs the stability compare
   logic dp_eff_c;
`ifdef SEG_CAPTURE_DP_EN
   assign dp_eff_c = dp;
`else
   logic unused_dp;
   assign unused_dp = dp;
   assign dp_eff_c  = 1'b1;
`endif

   logic [IW-1:0]   prev_q, prev_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            sampled_q, sampled_d;
   logic [3:0]      seen_q, seen_d;
   logic [3:0][3:0] slot_code_q, slot_code_d;
   logic [3:0]      slot_err_q, slot_err_d;
   logic [3:0]      slot_dp_q, slot_dp_d;
   logic [3:0][3:0] out_code_q, out_code_d;
   logic [3:0]      out_err_q, out_err_d;
   logic [3:0]      out_dp_q, out_dp_d;
   logic            fv_q, fv_d;

   logic [IW-1:0] cur_c;
   logic          sel_ok_c;
   logic          changed_c;
   logic [CW-1:0] cnt_inc_c;
   logic          sample_c;
   logic [4:0]    dec_c;

   assign cur_c     = {an, seg, dp_eff_c};
   assign sel_ok_c  = (an == 4'b1110) || (an == 4'b1101) || (an == 4'b1011) || (an == 4'b0111);
   assign changed_c = (cur_c != prev_q);
   assign cnt_inc_c = (cnt_q == SETTLE_C) ? cnt_q : cnt_q + CW'(1);
   assign sample_c  = sel_ok_c && !changed_c && !sampled_q && (cnt_inc_c == SETTLE_C);
   assign dec_c     = decode(seg);

   // Settle tracking, slot capture and frame publication
   always_comb begin
      prev_d      = cur_c;
      cnt_d       = cnt_q;
      sampled_d   = sampled_q;
      seen_d      = seen_q;
      slot_code_d = slot_code_q;
      slot_err_d  = slot_err_q;
      slot_dp_d   = slot_dp_q;
      out_code_d  = out_code_q;
      out_err_d   = out_err_q;
      out_dp_d    = out_dp_q;
      fv_d        = 1'b0;

      if (!sel_ok_c || changed_c) begin
         cnt_d     = '0;
         sampled_d = 1'b0;
      end else begin
         cnt_d = cnt_inc_c;
      end

      // Frame completion is handled before the slot write so a coincident sample opens the next frame
      if (seen_q == 4'hF) begin
         out_code_d = slot_code_q;
         out_err_d  = slot_err_q;
         out_dp_d   = slot_dp_q;
         fv_d       = 1'b1;
         seen_d     = 4'h0;
      end

      if (sample_c) begin
         sampled_d = 1'b1;
         for (int i = 0; i < 4; i++) begin
            if (!an[i]) begin
               slot_code_d[i] = dec_c[3:0];
               slot_err_d[i]  = dec_c[4];
               slot_dp_d[i]   = ~dp_eff_c;
               seen_d[i]      = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q      <= '1;
         cnt_q       <= '0;
         sampled_q   <= 1'b0;
         seen_q      <= '0;
         slot_code_q <= '0;
         slot_err_q  <= '0;
         slot_dp_q   <= '0;
         out_code_q  <= '0;
         out_err_q   <= '0;
         out_dp_q    <= '0;
         fv_q        <= 1'b0;
      end else begin
         prev_q      <= prev_d;
         cnt_q       <= cnt_d;
         sampled_q   <= sampled_d;
         seen_q      <= seen_d;
         slot_code_q <= slot_code_d;
         slot_err_q  <= slot_err_d;
         slot_dp_q   <= slot_dp_d;
         out_code_q  <= out_code_d;
         out_err_q   <= out_err_d;
         out_dp_q    <= out_dp_d;
         fv_q        <= fv_d;
      end
   end

   assign min_l       = out_code_q[3];
   assign min_r       = out_code_q[2];
   assign sec_l       = out_code_q[1];
   assign sec_r       = out_code_q[0];
   assign err         = out_err_q;
   assign dp_out      = out_dp_q;
   assign frame_valid = fv_q;

endmodule

// File: tb/tb_seg_capture.sv
// Bench for seg_capture (SETTLE=4): dwell-level reference model, directed scenarios and random segment streams.
module tb_seg_capture;

   localparam int unsigned SETTLE = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] an = 4'hF;
   logic [6:0] seg = 7'h7F;
   logic       dp = 1'b1;
   logic [3:0] min_l, min_r, sec_l, sec_r, err, dp_out;
   logic       frame_valid;

   seg_capture #(.SETTLE(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n), .an(an), .seg(seg), .dp(dp),
      .min_l(min_l), .min_r(min_r), .sec_l(sec_l), .sec_r(sec_r),
      .err(err), .dp_out(dp_out), .frame_valid(frame_valid)
   );

   always #5 clk = ~clk;

   int unsigned edges = 0;
   always @(posedge clk) edges++;

   int checks = 0;
   int fails = 0;
   int fv_count = 0;

   typedef struct {
      logic [15:0] codes;
      logic [3:0]  errs;
      logic [3:0]  dps;
      int unsigned at;
   } frame_t;

   frame_t      exp_q[$];
   frame_t      m_last;
   frame_t      mon_f;
   logic [15:0] m_codes;
   logic [3:0]  m_err, m_dp, m_seen;
   logic [11:0] m_key;
   int unsigned m_run_start;
   bit          m_sampled;

   logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   function automatic void model_decode(input logic [6:0] s, output logic [3:0] c, output logic e);
      c = 4'hF;
      e = 1'b1;
      if (s == 7'h7F) begin
         c = 4'hB;
         e = 1'b0;
      end
      for (int d = 0; d < 10; d++) begin
         if (pat[d] == s) begin
            c = 4'(d);
            e = 1'b0;
         end
      end
   endfunction

   function automatic logic [11:0] mkey(input logic [3:0] a, input logic [6:0] s, input logic d);
`ifdef SEG_CAPTURE_DP_EN
      return {a, s, d};
`else
      return {a, s, 1'b1 | d};
`endif
   endfunction

   function automatic logic model_dp(input logic d);
`ifdef SEG_CAPTURE_DP_EN
      return ~d;
`else
      return 1'b0 & d;
`endif
   endfunction

   // Holds one bus value for n cycles; predicts the sample and any frame it completes
   task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
      logic [11:0] k;
      logic        legal;
      int          idx;
      logic [3:0]  c;
      logic        e;
      frame_t      f;
      k = mkey(a, s, d);
      legal = ($countones(~a) == 1);
      idx = 0;
      if (k != m_key || !legal) begin
         m_run_start = edges;
         m_sampled = 1'b0;
      end
      m_key = k;
      if (legal && !m_sampled && (edges + n >= m_run_start + SETTLE + 1)) begin
         for (int i = 0; i < 4; i++) if (!a[i]) idx = i;
         model_decode(s, c, e);
         m_codes[idx*4 +: 4] = c;
         m_err[idx] = e;
         m_dp[idx] = model_dp(d);
         m_seen[idx] = 1'b1;
         m_sampled = 1'b1;
         if (m_seen == 4'hF) begin
            f.codes = m_codes;
            f.errs = m_err;
            f.dps = m_dp;
            f.at = m_run_start + SETTLE + 2;
            exp_q.push_back(f);
            m_last = f;
            m_seen = 4'h0;
         end
      end
      an = a;
      seg = s;
      dp = d;
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_codes = '0;
      m_err = '0;
      m_dp = '0;
      m_seen = '0;
      m_key = mkey(4'hF, 7'h7F, 1'b1);
      m_run_start = edges;
      m_sampled = 1'b0;
      m_last.codes = '0;
      m_last.errs = '0;
      m_last.dps = '0;
      m_last.at = 0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      an = 4'hF;
      seg = 7'h7F;
      dp = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // Every frame pulse is matched against the predicted frame and its edge
   always @(negedge clk) begin
      if (rst_n && frame_valid) begin
         fv_count++;
         checks++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL frame_unexpected: frame_valid=1 at edge %0d, required no frame", edges);
         end else begin
            mon_f = exp_q.pop_front();
            if ({min_l, min_r, sec_l, sec_r, err, dp_out, edges} !== {mon_f.codes, mon_f.errs, mon_f.dps, mon_f.at}) begin
               fails++;
               $display("FAIL frame_content: got digits=%h err=%b dp=%b edge=%0d, required digits=%h err=%b dp=%b edge=%0d",
                        {min_l, min_r, sec_l, sec_r}, err, dp_out, edges, mon_f.codes, mon_f.errs, mon_f.dps, mon_f.at);
            end
         end
      end
   end

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({min_l, min_r, sec_l, sec_r, err, dp_out} !== 24'h0) begin
         fails++;
         $display("FAIL reset_outputs: got %h, required 000000", {min_l, min_r, sec_l, sec_r, err, dp_out});
      end
      checks++;
      if (frame_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_frame_valid: got %b, required 0", frame_valid);
      end
   endtask

   task automatic test_static_time();
      int fv0;
      fv0 = fv_count;
      drive(4'b0111, 7'h79, 1'b1, 10);
      drive(4'b1011, 7'h24, 1'b1, 10);
      drive(4'b1101, 7'h30, 1'b1, 10);
      drive(4'b1110, 7'h19, 1'b1, 10);
      drive(4'hF, 7'h7F, 1'b1, 3);
      checks++;
      if ({min_l, min_r, sec_l, sec_r} !== 16'h1234 || err !== 4'h0) begin
         fails++;
         $display("FAIL static_time: got digits=%h err=%b, required 1234 err=0000", {min_l, min_r, sec_l, sec_r}, err);
      end
      checks++;
      if (fv_count - fv0 !== 1) begin
         fails++;
         $display("FAIL static_frames: got %0d pulses, required 1", fv_count - fv0);
      end
   endtask

   task automatic test_short_dwell();
      int fv0;
      apply_reset();
      fv0 = fv_count;
      for (int r = 0; r < 3; r++) begin
         drive(4'b0111, 7'h79, 1'b1, 3);
         drive(4'b1011, 7'h24, 1'b1, 3);
         drive(4'b1101, 7'h30, 1'b1, 3);
         drive(4'b1110, 7'h19, 1'b1, 3);
      end
      drive(4'hF, 7'h7F, 1'b1, 3);
      checks++;
      if (fv_count != fv0 || {min_l, min_r, sec_l, sec_r, err, dp_out} !== 24'h0) begin
         fails++;
         $display("FAIL short_dwell: got %0d pulses outputs=%h, required 0 pulses outputs=000000",
                  fv_count - fv0, {min_l, min_r, sec_l, sec_r, err, dp_out});
      end
   endtask

   task automatic test_glitch();
      drive(4'b1110, 7'h40, 1'b1, 3);
      drive(4'b1110, 7'h12, 1'b1, 10);
      drive(4'b1101, 7'h30, 1'b1, 10);
      drive(4'b1011, 7'h24, 1'b1, 10);
      drive(4'b0111, 7'h79, 1'b1, 10);
      drive(4'hF, 7'h7F, 1'b1, 3);
      checks++;
      if (sec_r !== 4'h5 || {min_l, min_r, sec_l} !== 12'h123) begin
         fails++;
         $display("FAIL glitch_dwell: got digits=%h, required 1235", {min_l, min_r, sec_l, sec_r});
      end
   endtask

   task automatic test_blank_bad();
      drive(4'b0111, 7'h7F, 1'b1, 8);
      drive(4'b1011, 7'h78, 1'b1, 8);
      drive(4'b1101, 7'h10, 1'b1, 8);
      drive(4'b1110, 7'h55, 1'b1, 8);
      drive(4'hF, 7'h7F, 1'b1, 3);
      checks++;
      if ({min_l, min_r, sec_l, sec_r} !== 16'hB79F || err !== 4'b0001) begin
         fails++;
         $display("FAIL blank_bad: got digits=%h err=%b, required B79F err=0001", {min_l, min_r, sec_l, sec_r}, err);
      end
   endtask

   task automatic test_dp();
      logic [3:0] want;
`ifdef SEG_CAPTURE_DP_EN
      want = 4'b0100;
`else
      want = 4'b0000;
`endif
      drive(4'b0111, 7'h02, 1'b1, 7);
      drive(4'b1011, 7'h00, 1'b0, 7);
      drive(4'b1101, 7'h12, 1'b1, 7);
      drive(4'b1110, 7'h40, 1'b1, 7);
      drive(4'hF, 7'h7F, 1'b1, 3);
      checks++;
      if (dp_out !== want || {min_l, min_r, sec_l, sec_r} !== 16'h6850) begin
         fails++;
         $display("FAIL dp_capture: got dp_out=%b digits=%h, required dp_out=%b digits=6850",
                  dp_out, {min_l, min_r, sec_l, sec_r}, want);
      end
   endtask

   task automatic test_illegal_anode_reset();
      int fv0;
      fv0 = fv_count;
      drive(4'b0111, 7'h12, 1'b1, 3);
      drive(4'b0011, 7'h79, 1'b1, 20);
      drive(4'b1011, 7'h24, 1'b1, 3);
      drive(4'b0011, 7'h24, 1'b1, 20);
      drive(4'b0000, 7'h00, 1'b1, 20);
      checks++;
      if (fv_count != fv0) begin
         fails++;
         $display("FAIL illegal_anode: got %0d pulses, required 0", fv_count - fv0);
      end
      drive(4'b0111, 7'h00, 1'b1, 8);
      drive(4'b1011, 7'h00, 1'b1, 8);
      apply_reset();
      fv0 = fv_count;
      drive(4'b1110, 7'h00, 1'b1, 8);
      drive(4'b1101, 7'h78, 1'b1, 8);
      drive(4'b1011, 7'h02, 1'b1, 8);
      drive(4'b0111, 7'h12, 1'b1, 8);
      drive(4'hF, 7'h7F, 1'b1, 3);
      checks++;
      if (fv_count - fv0 !== 1 || {min_l, min_r, sec_l, sec_r} !== 16'h5678) begin
         fails++;
         $display("FAIL reset_midframe: got %0d pulses digits=%h, required 1 pulse digits=5678",
                  fv_count - fv0, {min_l, min_r, sec_l, sec_r});
      end
   endtask

   task automatic test_random();
      logic [3:0] a;
      logic [6:0] s;
      int         sel;
      for (int t = 0; t < 400; t++) begin
         if ($urandom_range(0, 9) < 8) begin
            a = 4'hF;
            a[$urandom_range(0, 3)] = 1'b0;
         end else begin
            a = 4'($urandom_range(0, 15));
         end
         sel = $urandom_range(0, 9);
         if (sel < 7) s = pat[$urandom_range(0, 9)];
         else if (sel == 7) s = 7'h7F;
         else s = 7'($urandom_range(0, 127));
         drive(a, s, 1'($urandom_range(0, 1)), $urandom_range(1, 9));
      end
      drive(4'hF, 7'h7F, 1'b1, 3);
      checks++;
      if ({min_l, min_r, sec_l, sec_r, err, dp_out} !== {m_last.codes, m_last.errs, m_last.dps}) begin
         fails++;
         $display("FAIL random_final: got %h, required %h",
                  {min_l, min_r, sec_l, sec_r, err, dp_out}, {m_last.codes, m_last.errs, m_last.dps});
      end
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s_missing_frame: got %0d predicted frames never seen, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      test_reset();
      test_static_time();
      check_drained("static_time");
      test_short_dwell();
      check_drained("short_dwell");
      test_glitch();
      check_drained("glitch");
      test_blank_bad();
      check_drained("blank_bad");
      test_dp();
      check_drained("dp");
      test_illegal_anode_reset();
      check_drained("illegal_reset");
      test_random();
      check_drained("random");
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
